// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// slave: the decode stage's view; master: the producer/consumer view.
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [6:0]            out_opcode;
  logic [2:0]            out_funct3;
  logic [6:0]            out_funct7;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_imm;
  logic [2:0]            out_fmt;
  logic                  out_uses_rs1;
  logic                  out_uses_rs2;
  logic                  out_writes_rd;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV32E decode stage: combinational field decode feeding a
// DEPTH-entry in-order output queue with flush and synchronous reset.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  // Register-index bits that must be clear for this register file size.
  localparam logic [4:0] HI_MASK = 5'(32'h1f << REG_ADDR_W);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [2:0]            fmt;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  writes_rd;
    logic                  illegal;
  } entry_t;

  logic [31:0]        instr;
  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [4:0]         rs1f, rs2f, rdf;
  fmt_e               fmt;
  logic               known, bad_enc, reg_bad, illegal;
  logic               uses_rs1, uses_rs2, writes_rd;
  logic signed [31:0] imm32;
  entry_t             dec;

  entry_t             mem [DEPTH];
  logic [PW-1:0]      wptr, rptr;
  logic [CW-1:0]      count;
  logic               push, pop, out_valid;
  entry_t             head;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1f   = instr[19:15];
  assign rs2f   = instr[24:20];
  assign rdf    = instr[11:7];

  // Classify the instruction, build its immediate and legality, form the queue entry.
  always_comb begin
    fmt   = FMT_NONE;
    known = 1'b1;
    case (opcode)
      7'b0110011:             fmt = FMT_R;
      7'b0010011:             fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHIFT : FMT_I;
      7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:             fmt = FMT_S;
      7'b1100011:             fmt = FMT_B;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b0001111, 7'b1110011: fmt = FMT_NONE;
      default:                known = 1'b0;
    endcase

    case (fmt)
      FMT_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm32 = {instr[31:12], 12'b0};
      FMT_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHIFT: imm32 = {27'b0, instr[24:20]};
      default:   imm32 = '0;
    endcase

    uses_rs1  = fmt inside {FMT_R, FMT_SHIFT, FMT_I, FMT_S, FMT_B};
    uses_rs2  = fmt inside {FMT_R, FMT_S, FMT_B};
    writes_rd = fmt inside {FMT_R, FMT_SHIFT, FMT_I, FMT_U, FMT_J};

    bad_enc = 1'b0;
    if (fmt == FMT_R)
      bad_enc = !(f7 == 7'h00 || f7 == 7'h20) ||
                (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
    // funct7 0x20 is the arithmetic right shift; only its pairing with funct3 001 is rejected.
    if (fmt == FMT_SHIFT)
      bad_enc = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 == 3'b001);

    reg_bad = (uses_rs1  && |(rs1f & HI_MASK)) ||
              (uses_rs2  && |(rs2f & HI_MASK)) ||
              (writes_rd && |(rdf  & HI_MASK));

    illegal = (instr[1:0] != 2'b11) || !known || bad_enc || reg_bad;

    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = opcode;
    if (illegal) begin
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
    end else begin
      dec.fmt       = fmt;
      dec.funct3    = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B, FMT_SHIFT}) ? f3 : 3'b000;
      dec.funct7    = (fmt inside {FMT_R, FMT_SHIFT}) ? f7 : 7'b0;
      dec.rs1       = uses_rs1  ? rs1f[REG_ADDR_W-1:0] : '0;
      dec.rs2       = uses_rs2  ? rs2f[REG_ADDR_W-1:0] : '0;
      dec.rd        = writes_rd ? rdf[REG_ADDR_W-1:0]  : '0;
      dec.imm       = XLEN'(imm32);
      dec.uses_rs1  = uses_rs1;
      dec.uses_rs2  = uses_rs2;
      dec.writes_rd = writes_rd;
    end
  end

  assign bus.in_ready = !reset && (count < FULL);
  assign out_valid    = !reset && (count != '0);
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign pop          = out_valid && bus.out_ready && !flush;

  // Queue storage: write the decoded entry at the tail on each push.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  // Queue pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry, forced to zero when nothing is valid.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rptr];
  end

  assign bus.out_valid     = out_valid;
  assign bus.out_pc        = head.pc;
  assign bus.out_opcode    = head.opcode;
  assign bus.out_funct3    = head.funct3;
  assign bus.out_funct7    = head.funct7;
  assign bus.out_rs1       = head.rs1;
  assign bus.out_rs2       = head.rs2;
  assign bus.out_rd        = head.rd;
  assign bus.out_imm       = head.imm;
  assign bus.out_fmt       = head.fmt;
  assign bus.out_uses_rs1  = head.uses_rs1;
  assign bus.out_uses_rs2  = head.uses_rs2;
  assign bus.out_writes_rd = head.writes_rd;
  assign bus.out_illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I instance (DEPTH 2) plus an RV32E instance.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) b0 ();
  decode_stage_if #(.XLEN(32), .REG_ADDR_W(4)) b1 ();

  decode_stage #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(2)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b0));
  decode_stage #(.XLEN(32), .REG_ADDR_W(4), .DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b1));

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        u1, u2, wr, ill;
  } ent_t;

  ent_t sb[$];
  ent_t exp_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic ent_t mk(input logic [31:0] pc, input logic [6:0] opc,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [2:0] fmt, input logic u1,
                              input logic u2, input logic wr, input logic ill);
    ent_t e;
    e = '{pc, opc, f3, f7, rs1, rs2, rd, imm, fmt, u1, u2, wr, ill};
    return e;
  endfunction

  function automatic ent_t obs0();
    ent_t e;
    e = '{b0.out_pc, b0.out_opcode, b0.out_funct3, b0.out_funct7,
          b0.out_rs1, b0.out_rs2, b0.out_rd, b0.out_imm, b0.out_fmt,
          b0.out_uses_rs1, b0.out_uses_rs2, b0.out_writes_rd, b0.out_illegal};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive the producer side; record the expected entry if this cycle pushes.
  task automatic offer(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input ent_t e);
    b0.in_valid = v;
    b0.in_instr = instr;
    b0.in_pc    = pc;
    if (v && b0.in_ready && !flush && !reset) sb.push_back(e);
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF10093;
  localparam logic [31:0] I_SW   = 32'hFE512E23;
  localparam logic [31:0] I_JAL  = 32'hFF9FF06F;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LUI  = 32'h123451B7;
  localparam logic [31:0] I_SLLI = 32'h00329213;
  localparam logic [31:0] I_SUB  = 32'h407302B3;
  localparam logic [31:0] I_X16  = 32'h00208833;

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    b0.in_valid = 1'b0; b0.in_instr = '0; b0.in_pc = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_instr = '0; b1.in_pc = '0; b1.out_ready = 1'b0;
    tick(); tick();
    n_chk++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", b0.in_ready); end
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_low: got %b want 0", b0.out_valid); end
    reset = 1'b0;
    tick();
    n_chk++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", b0.in_ready); end
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", b0.out_valid); end
    n_chk++; if (obs0() !== '0) begin n_fail++; $display("FAIL post_reset_idle_data: got %h want 0", obs0()); end
  endtask

  task automatic test_addi();
    b0.out_ready = 1'b1;
    offer(1'b1, I_ADDI, 32'h100, mk(32'h100, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 3'd1, 1, 0, 1, 0));
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_comb_path: got %b want 0", b0.out_valid); end
    tick();
    offer(1'b0, '0, '0, '0);
    n_chk++;
    if (!b0.out_valid || sb.size() == 0) begin n_fail++; $display("FAIL addi_latency: out_valid=%b queued=%0d want 1 entry", b0.out_valid, sb.size()); end
    else begin
      exp_e = sb.pop_front();
      if (obs0() !== exp_e) begin n_fail++; $display("FAIL addi_entry: got %h want %h", obs0(), exp_e); end
    end
    tick();
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_duplicate: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_back_to_back();
    b0.out_ready = 1'b1;
    offer(1'b1, I_SW, 32'h104, mk(32'h104, 7'h23, 3'd2, 7'h00, 5'd2, 5'd5, 5'd0, 32'hFFFFFFFC, 3'd2, 1, 1, 0, 0));
    tick();
    offer(1'b1, I_JAL, 32'h108, mk(32'h108, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 3'd5, 0, 0, 1, 0));
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (!b0.out_valid || sb.size() == 0) begin n_fail++; $display("FAIL b2b_valid_%0d: out_valid=%b queued=%0d want 1", c, b0.out_valid, sb.size()); end
      else begin
        exp_e = sb.pop_front();
        if (obs0() !== exp_e) begin n_fail++; $display("FAIL b2b_entry_%0d: got %h want %h", c, obs0(), exp_e); end
      end
      tick();
      offer(1'b0, '0, '0, '0);
    end
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_backpressure();
    logic accepted;
    b0.out_ready = 1'b0;
    offer(1'b1, I_ADD, 32'h200, mk(32'h200, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 1, 1, 1, 0));
    tick();
    offer(1'b1, I_LUI, 32'h204, mk(32'h204, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'h12345000, 3'd4, 0, 0, 1, 0));
    tick();
    offer(1'b1, I_SLLI, 32'h208, mk(32'h208, 7'h13, 3'd1, 7'h00, 5'd5, 5'd0, 5'd4, 32'h3, 3'd6, 1, 0, 1, 0));
    n_chk++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", b0.in_ready); end
    tick();
    n_chk++;
    if (sb.size() == 0 || obs0() !== sb[0]) begin n_fail++; $display("FAIL bp_head_stable: got %h queued=%0d", obs0(), sb.size()); end
    b0.out_ready = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 12 && (sb.size() > 0 || !accepted); c++) begin
      if (!accepted) begin
        offer(1'b1, I_SLLI, 32'h208, mk(32'h208, 7'h13, 3'd1, 7'h00, 5'd5, 5'd0, 5'd4, 32'h3, 3'd6, 1, 0, 1, 0));
        accepted = b0.in_ready;
      end else offer(1'b0, '0, '0, '0);
      if (b0.out_valid) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra_output: got pc=%h want none", b0.out_pc); end
        else begin
          exp_e = sb.pop_front();
          if (obs0() !== exp_e) begin n_fail++; $display("FAIL bp_order: got %h want %h", obs0(), exp_e); end
        end
      end
      tick();
    end
    offer(1'b0, '0, '0, '0);
    n_chk++; if (sb.size() != 0 || !accepted) begin n_fail++; $display("FAIL bp_drain_timeout: queued=%0d accepted=%b want 0/1", sb.size(), accepted); end
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_flush();
    b0.out_ready = 1'b0;
    offer(1'b1, I_ADD, 32'h300, mk(32'h300, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 1, 1, 1, 0));
    tick();
    offer(1'b1, I_LUI, 32'h304, mk(32'h304, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'h12345000, 3'd4, 0, 0, 1, 0));
    tick();
    flush = 1'b1;
    offer(1'b1, I_SUB, 32'h308, '0);
    tick();
    flush = 1'b0;
    offer(1'b0, '0, '0, '0);
    sb.delete();
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", b0.out_valid); end
    n_chk++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", b0.in_ready); end
    b0.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_%0d: got out_valid %b pc=%h want 0", c, b0.out_valid, b0.out_pc); end
    end
  endtask

  task automatic test_illegal();
    b0.out_ready = 1'b1;
    offer(1'b1, 32'h00000000, 32'h400, mk(32'h400, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 0, 0, 0, 1));
    tick();
    offer(1'b1, 32'h40209033, 32'h404, mk(32'h404, 7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 0, 0, 0, 1));
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (!b0.out_valid || sb.size() == 0) begin n_fail++; $display("FAIL illegal_valid_%0d: out_valid=%b queued=%0d want 1", c, b0.out_valid, sb.size()); end
      else begin
        exp_e = sb.pop_front();
        if (obs0() !== exp_e) begin n_fail++; $display("FAIL illegal_entry_%0d: got %h want %h", c, obs0(), exp_e); end
      end
      tick();
      offer(1'b0, '0, '0, '0);
    end
  endtask

  task automatic test_rv32e();
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_instr = I_X16; b1.in_pc = 32'h500;
    offer(1'b1, I_X16, 32'h500, mk(32'h500, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd16, 32'h0, 3'd0, 1, 1, 1, 0));
    tick();
    b1.in_valid = 1'b0;
    offer(1'b0, '0, '0, '0);
    n_chk++;
    if (!b0.out_valid || sb.size() == 0) begin n_fail++; $display("FAIL rv32i_x16_valid: out_valid=%b want 1", b0.out_valid); end
    else begin
      exp_e = sb.pop_front();
      if (obs0() !== exp_e) begin n_fail++; $display("FAIL rv32i_x16_entry: got %h want %h", obs0(), exp_e); end
    end
    n_chk++;
    if ({b1.out_valid, b1.out_illegal, b1.out_fmt, b1.out_rd, b1.out_rs1, b1.out_opcode, b1.out_pc} !==
        {1'b1, 1'b1, 3'd7, 4'd0, 4'd0, 7'h33, 32'h500}) begin
      n_fail++;
      $display("FAIL rv32e_x16_illegal: got valid=%b ill=%b fmt=%0d rd=%0d rs1=%0d opc=%h pc=%h want 1 1 7 0 0 33 00000500",
               b1.out_valid, b1.out_illegal, b1.out_fmt, b1.out_rd, b1.out_rs1, b1.out_opcode, b1.out_pc);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    b0.out_ready = 1'b0;
    offer(1'b1, I_ADD, 32'h600, '0);
    tick();
    offer(1'b1, I_LUI, 32'h604, '0);
    tick();
    reset = 1'b1;
    #1;
    offer(1'b1, I_SUB, 32'h608, '0);
    n_chk++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 0", b0.in_ready); end
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", b0.out_valid); end
    tick();
    reset = 1'b0;
    offer(1'b0, '0, '0, '0);
    sb.delete();
    #1;
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL after_reset_out_valid: got %b want 0", b0.out_valid); end
    n_chk++; if (obs0() !== '0) begin n_fail++; $display("FAIL after_reset_data: got %h want 0", obs0()); end
    n_chk++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL after_reset_in_ready: got %b want 1", b0.in_ready); end
    b0.out_ready = 1'b1;
    offer(1'b1, I_ADDI, 32'h700, mk(32'h700, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 3'd1, 1, 0, 1, 0));
    tick();
    offer(1'b0, '0, '0, '0);
    n_chk++;
    if (!b0.out_valid || sb.size() == 0) begin n_fail++; $display("FAIL after_reset_latency: out_valid=%b want 1", b0.out_valid); end
    else begin
      exp_e = sb.pop_front();
      if (obs0() !== exp_e) begin n_fail++; $display("FAIL after_reset_entry: got %h want %h", obs0(), exp_e); end
    end
    tick();
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL after_reset_stale: got %b pc=%h want 0", b0.out_valid, b0.out_pc); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_rv32e();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
